pm_bus_responder: RTL and testbench
===================================

# pm_bus_responder

Target-side bus controller for the Pokémon Mini system bus, at the far end of the S1C88 core's bus. It decodes each CPU read/write cycle into BIOS ROM, internal work RAM, the I/O register window or the cartridge port, and returns read data to the CPU. It also keeps open-bus read data, reports interrupt acknowledges and latches sticky bus faults. Instantiated in the top level between the CPU and the memory/peripheral blocks.

## Interface
- RAM_AW, 12, work RAM address width (2^RAM_AW bytes)
- clk  in  1  system clock (all state on negedge clk, same edge the CPU updates its address)
- reset  in  1  asynchronous, active-high; clock clk
- cpu_address  in  24  CPU address
- cpu_data_out  in  8  CPU write data
- cpu_read  in  1  CPU read strobe, high for one clk starting at a posedge
- cpu_write  in  1  CPU write strobe
- cpu_bus_status  in  2  0 idle, 1 irq read, 2 mem write, 3 mem read
- cpu_iack  in  1  CPU interrupt acknowledge level
- cpu_data_in  out  8  read data to CPU (registered)
- bios_addr  out  12  cpu_address[11:0], combinational
- bios_data  in  8  BIOS byte, sampled at capture edge
- cart_addr  out  21  cpu_address[20:0], or latched write address during cart_wr
- cart_rd  out  1  cpu_read & cart select, combinational
- cart_data  in  8  cartridge read data
- cart_wr  out  1  one-clk registered write pulse
- cart_wdata  out  8  latched write data
- io_addr  out  8  cpu_address[7:0], or latched write address during io_wr
- io_rd  out  1  cpu_read & io select, combinational
- io_rdata  in  8  I/O read data
- io_wr  out  1  one-clk registered write pulse
- io_wdata  out  8  latched write data
- irq_ack  out  1  one-clk pulse on cpu_iack rising edge
- bus_fault  out  1  sticky fault flag
- fault_clr  in  1  clears bus_fault

## Operation
- Decode on cpu_address:
  - BIOS: 0x000000–0x000FFF
  - RAM: 0x001000–0x001FFF, index = addr[RAM_AW-1:0]
  - IO: 0x002000–0x0020FF
  - CART: 0x002100–0x1FFFFF
  - UNMAPPED: everything else
- Read capture: at every negedge with cpu_read=1, load cpu_data_in from the selected source (bios_data, RAM array, io_rdata, cart_data).
- UNMAPPED read: cpu_data_in holds its previous value (open bus). No fault.
- Write commit: at the first negedge where cpu_write=1 and cpu_write was 0 at the previous negedge.
  - A strobe held for multiple cycles commits exactly once.
  - Commit requires cpu_bus_status=2. Otherwise the write is dropped and bus_fault is set.
- Write targets:
  - RAM: written at the commit edge.
  - IO/CART: address and data latched; io_wr/cart_wr high for the following clk.
  - BIOS or UNMAPPED: dropped, bus_fault set.
- cpu_read and cpu_write at the same negedge: write handled as above, read ignored (cpu_data_in unchanged), bus_fault set.
- irq_ack: registered rising-edge detect of cpu_iack. Reads during iack are decoded normally, so the vector fetch at 0x000000/0x000001 returns BIOS bytes.
- fault_clr has priority below a same-edge fault set: the flag stays 1.
- Reset values:
  - cpu_data_in=0xFF
  - cart_wr, io_wr, irq_ack, bus_fault = 0
  - write-edge and iack-edge history = 0
  - cart_wdata, io_wdata = 0
  - RAM contents are not cleared.
  - Reset mid-write: pending io_wr/cart_wr pulse is cancelled.

## Timing
- CPU read: address valid from negedge N; cpu_read rises at posedge P1; capture at negedge N1; CPU samples cpu_data_in at posedge P2. Read latency is therefore one clk.
- bios_data, io_rdata and cart_data must settle within N→N1 (one clk).
- Write: RAM updated at the commit negedge. io_wr/cart_wr are asserted from the commit negedge to the next negedge. io_addr/cart_addr show the latched address during the pulse.
- irq_ack is asserted at the negedge after cpu_iack is first seen high, and lasts one clk.
- Back-to-back reads on consecutive cycles are supported. Back-to-back writes require cpu_write to be low for at least one negedge between them.

## Test plan
- Reset, then read 0x000000 with bios_data=0x34 → cpu_data_in 0xFF after reset, then 0x34 at the capture negedge; bus_fault=0.
- Write 0xA5 to 0x001010 (status=2), then read 0x001010 → cpu_data_in=0xA5. Hold cpu_write 3 clks with data 0x5A → RAM still writes once, value 0x5A.
- Read 0x002100 with cart_data=0x77, then read 0x300000 → 0x77 both times (open bus); cart_rd high only during the first read.
- Write 0x3C to 0x002020 → io_wr one clk, io_addr=0x20, io_wdata=0x3C. Write to 0x000100 → bus_fault=1, held until fault_clr, which clears it at the next negedge.
- cpu_iack rises and is held 6 clks → irq_ack exactly one clk. Reads of 0x000000/0x000001 with BIOS bytes 0x00/0x21 return 0x00, 0x21.
- Assert reset during an io_wr pulse → io_wr=0 immediately; cpu_data_in=0xFF; RAM byte written earlier is still readable after reset.

Source files
------------

// File: rtl/pm_bus_responder_if.sv
// rtl/pm_bus_responder_if.sv - CPU-side bus bundle between the S1C88 core and the bus responder
//
// Purpose: groups the CPU cycle signals so the core and the responder share one port.
// Signals:
//   cpu_address     24  CPU address
//   cpu_data_out     8  CPU write data
//   cpu_read         1  read strobe
//   cpu_write        1  write strobe
//   cpu_bus_status   2  0 idle, 1 irq read, 2 mem write, 3 mem read
//   cpu_iack         1  interrupt acknowledge level
//   cpu_data_in      8  registered read data back to the CPU
// Modports: master = CPU side, slave = responder side.
interface pm_bus_responder_if;
  logic [23:0] cpu_address;
  logic [7:0]  cpu_data_out;
  logic        cpu_read;
  logic        cpu_write;
  logic [1:0]  cpu_bus_status;
  logic        cpu_iack;
  logic [7:0]  cpu_data_in;

  modport master (
    output cpu_address, cpu_data_out, cpu_read, cpu_write, cpu_bus_status, cpu_iack,
    input  cpu_data_in
  );

  modport slave (
    input  cpu_address, cpu_data_out, cpu_read, cpu_write, cpu_bus_status, cpu_iack,
    output cpu_data_in
  );
endinterface

// File: rtl/pm_bus_responder.sv
// rtl/pm_bus_responder.sv - Pokemon Mini system bus target: decode, read return, writes, iack, faults
//
// Purpose: decodes CPU cycles into BIOS / work RAM / IO window / cartridge, captures read
// data, commits writes once per strobe, detects iack rising edges and latches bus faults.
// All state changes on negedge clk (the edge the CPU moves its address on).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cpu (slave)           CPU bus bundle (address, data, strobes, status, iack, read data)
//   bios_addr/bios_data   BIOS ROM address out, byte in
//   cart_*                cartridge address, read strobe, read data, write pulse and data
//   io_*                  IO window address, read strobe, read data, write pulse and data
//   irq_ack               one-clk pulse on cpu_iack rising edge
//   bus_fault/fault_clr   sticky fault flag and its clear
module pm_bus_responder #(
  parameter int RAM_AW = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  pm_bus_responder_if.slave      cpu,
  output logic [11:0]            bios_addr,
  input  logic [7:0]             bios_data,
  output logic [20:0]            cart_addr,
  output logic                   cart_rd,
  input  logic [7:0]             cart_data,
  output logic                   cart_wr,
  output logic [7:0]             cart_wdata,
  output logic [7:0]             io_addr,
  output logic                   io_rd,
  input  logic [7:0]             io_rdata,
  output logic                   io_wr,
  output logic [7:0]             io_wdata,
  output logic                   irq_ack,
  output logic                   bus_fault,
  input  logic                   fault_clr
);

  logic [7:0] ram_mem [0:(1<<RAM_AW)-1];

  logic [23:0] addr;
  logic        sel_bios, sel_ram, sel_io, sel_cart, sel_none;
  logic        commit_edge, write_ok, fault_set;
  logic [7:0]  rd_data;

  logic [7:0]  data_in_q,    data_in_d;
  logic        write_prev_q, write_prev_d;
  logic        iack_prev_q,  iack_prev_d;
  logic        irq_ack_q,    irq_ack_d;
  logic        fault_q,      fault_d;
  logic        io_wr_q,      io_wr_d;
  logic [7:0]  io_waddr_q,   io_waddr_d;
  logic [7:0]  io_wdata_q,   io_wdata_d;
  logic        cart_wr_q,    cart_wr_d;
  logic [20:0] cart_waddr_q, cart_waddr_d;
  logic [7:0]  cart_wdata_q, cart_wdata_d;

  assign addr     = cpu.cpu_address;
  assign sel_bios = (addr <= 24'h000FFF);
  assign sel_ram  = (addr >= 24'h001000) && (addr <= 24'h001FFF);
  assign sel_io   = (addr >= 24'h002000) && (addr <= 24'h0020FF);
  assign sel_cart = (addr >= 24'h002100) && (addr <= 24'h1FFFFF);
  assign sel_none = !(sel_bios || sel_ram || sel_io || sel_cart);

  // A write commits only on the first edge of a strobe, so a held strobe writes once.
  assign commit_edge = cpu.cpu_write && !write_prev_q;
  assign write_ok    = commit_edge && (cpu.cpu_bus_status == 2'd2);
  assign fault_set   = (commit_edge && ((cpu.cpu_bus_status != 2'd2) || sel_bios || sel_none))
                     || (cpu.cpu_read && cpu.cpu_write);

  always_comb begin
    rd_data = data_in_q;
    if (sel_bios)      rd_data = bios_data;
    else if (sel_ram)  rd_data = ram_mem[addr[RAM_AW-1:0]];
    else if (sel_io)   rd_data = io_rdata;
    else if (sel_cart) rd_data = cart_data;
  end

  always_comb begin
    data_in_d    = data_in_q;
    write_prev_d = cpu.cpu_write;
    iack_prev_d  = cpu.cpu_iack;
    irq_ack_d    = cpu.cpu_iack && !iack_prev_q;
    io_wr_d      = 1'b0;
    io_waddr_d   = io_waddr_q;
    io_wdata_d   = io_wdata_q;
    cart_wr_d    = 1'b0;
    cart_waddr_d = cart_waddr_q;
    cart_wdata_d = cart_wdata_q;
    fault_d      = fault_q;

    // Unmapped reads leave the previous byte in place (open bus); reads that collide
    // with a write are ignored.
    if (cpu.cpu_read && !cpu.cpu_write && !sel_none)
      data_in_d = rd_data;

    if (write_ok && sel_io) begin
      io_wr_d    = 1'b1;
      io_waddr_d = addr[7:0];
      io_wdata_d = cpu.cpu_data_out;
    end
    if (write_ok && sel_cart) begin
      cart_wr_d    = 1'b1;
      cart_waddr_d = addr[20:0];
      cart_wdata_d = cpu.cpu_data_out;
    end

    // A fault raised on the same edge wins over the clear.
    if (fault_set)      fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      data_in_q    <= 8'hFF;
      write_prev_q <= 1'b0;
      iack_prev_q  <= 1'b0;
      irq_ack_q    <= 1'b0;
      fault_q      <= 1'b0;
      io_wr_q      <= 1'b0;
      io_waddr_q   <= 8'h00;
      io_wdata_q   <= 8'h00;
      cart_wr_q    <= 1'b0;
      cart_waddr_q <= 21'h0;
      cart_wdata_q <= 8'h00;
    end else begin
      data_in_q    <= data_in_d;
      write_prev_q <= write_prev_d;
      iack_prev_q  <= iack_prev_d;
      irq_ack_q    <= irq_ack_d;
      fault_q      <= fault_d;
      io_wr_q      <= io_wr_d;
      io_waddr_q   <= io_waddr_d;
      io_wdata_q   <= io_wdata_d;
      cart_wr_q    <= cart_wr_d;
      cart_waddr_q <= cart_waddr_d;
      cart_wdata_q <= cart_wdata_d;
    end
  end

  // Work RAM has no reset; its contents survive a reset.
  always_ff @(negedge clk) begin
    if (!reset && write_ok && sel_ram)
      ram_mem[addr[RAM_AW-1:0]] <= cpu.cpu_data_out;
  end

  assign cpu.cpu_data_in = data_in_q;
  assign bios_addr       = addr[11:0];
  assign cart_rd         = cpu.cpu_read && sel_cart;
  assign io_rd           = cpu.cpu_read && sel_io;
  // During a write pulse the latched address is presented instead of the live one.
  assign cart_addr       = cart_wr_q ? cart_waddr_q : addr[20:0];
  assign io_addr         = io_wr_q ? io_waddr_q : addr[7:0];
  assign cart_wr         = cart_wr_q;
  assign cart_wdata      = cart_wdata_q;
  assign io_wr           = io_wr_q;
  assign io_wdata        = io_wdata_q;
  assign irq_ack         = irq_ack_q;
  assign bus_fault       = fault_q;

endmodule

// File: tb/tb_pm_bus_responder.sv
// tb/tb_pm_bus_responder.sv - randomized self-checking bench for pm_bus_responder
module tb_pm_bus_responder;

  localparam int R_BIOS = 0, R_RAM = 1, R_IO = 2, R_CART = 3, R_NONE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] bios_addr;
  logic [7:0]  bios_data = 8'h00;
  logic [20:0] cart_addr;
  logic        cart_rd;
  logic [7:0]  cart_data = 8'h00;
  logic        cart_wr;
  logic [7:0]  cart_wdata;
  logic [7:0]  io_addr;
  logic        io_rd;
  logic [7:0]  io_rdata = 8'h00;
  logic        io_wr;
  logic [7:0]  io_wdata;
  logic        irq_ack;
  logic        bus_fault;
  logic        fault_clr = 1'b0;

  pm_bus_responder_if bus ();

  pm_bus_responder #(.RAM_AW(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu        (bus),
    .bios_addr  (bios_addr),
    .bios_data  (bios_data),
    .cart_addr  (cart_addr),
    .cart_rd    (cart_rd),
    .cart_data  (cart_data),
    .cart_wr    (cart_wr),
    .cart_wdata (cart_wdata),
    .io_addr    (io_addr),
    .io_rd      (io_rd),
    .io_rdata   (io_rdata),
    .io_wr      (io_wr),
    .io_wdata   (io_wdata),
    .irq_ack    (irq_ack),
    .bus_fault  (bus_fault),
    .fault_clr  (fault_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: RAM contents, open-bus byte and fault flag.
  logic [7:0] ram_m [0:4095];
  logic [7:0] last_m  = 8'hFF;
  logic       fault_m = 1'b0;
  logic       clr_on_write = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int region(input logic [23:0] a);
    if (a < 24'h001000) return R_BIOS;
    if (a < 24'h002000) return R_RAM;
    if (a < 24'h002100) return R_IO;
    if (a < 24'h200000) return R_CART;
    return R_NONE;
  endfunction

  task automatic do_read(input logic [23:0] a, input logic [7:0] b, input logic [7:0] i, input logic [7:0] c);
    logic [7:0] exp;
    int r;
    r = region(a);
    @(posedge clk); #1;
    bus.cpu_address = a; bus.cpu_read = 1'b1; bus.cpu_bus_status = 2'd3;
    bios_data = b; io_rdata = i; cart_data = c;
    #1;
    chk("cart_rd", cart_rd, r == R_CART);
    chk("io_rd", io_rd, r == R_IO);
    chk("bios_addr", bios_addr, a[11:0]);
    case (r)
      R_BIOS:  exp = b;
      R_RAM:   exp = ram_m[a[11:0]];
      R_IO:    exp = i;
      R_CART:  exp = c;
      default: exp = last_m;
    endcase
    @(negedge clk); #1;
    chk("rdata", bus.cpu_data_in, exp);
    last_m = exp;
    chk("rd_fault", bus_fault, fault_m);
    @(posedge clk); #1;
    bus.cpu_read = 1'b0; bus.cpu_bus_status = 2'd0;
    #1;
    chk("cart_rd_idle", cart_rd, 1'b0);
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] d, input logic [1:0] st,
                          input int hold, input logic with_read);
    int r;
    logic ok;
    r  = region(a);
    ok = (st == 2'd2);
    @(posedge clk); #1;
    bus.cpu_address = a; bus.cpu_data_out = d; bus.cpu_write = 1'b1;
    bus.cpu_bus_status = st; bus.cpu_read = with_read; fault_clr = clr_on_write;
    @(negedge clk); #1;
    if (with_read || !ok || r == R_BIOS || r == R_NONE) fault_m = 1'b1;
    else if (clr_on_write) fault_m = 1'b0;
    if (ok && r == R_RAM) ram_m[a[11:0]] = d;
    chk("wr_io_pulse", io_wr, ok && r == R_IO);
    chk("wr_cart_pulse", cart_wr, ok && r == R_CART);
    if (ok && r == R_IO) begin
      chk("io_addr", io_addr, a[7:0]);
      chk("io_wdata", io_wdata, d);
    end
    if (ok && r == R_CART) begin
      chk("cart_addr", cart_addr, a[20:0]);
      chk("cart_wdata", cart_wdata, d);
    end
    chk("wr_rdata_kept", bus.cpu_data_in, last_m);
    chk("wr_fault", bus_fault, fault_m);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #1;
      bus.cpu_data_out = 8'($urandom);
      fault_clr = 1'b0;
      @(negedge clk); #1;
      chk("hold_io_wr", io_wr, 1'b0);
      chk("hold_cart_wr", cart_wr, 1'b0);
    end
    @(posedge clk); #1;
    bus.cpu_write = 1'b0; bus.cpu_read = 1'b0; bus.cpu_bus_status = 2'd0; fault_clr = 1'b0;
    @(negedge clk); #1;
    chk("post_io_wr", io_wr, 1'b0);
    chk("post_cart_wr", cart_wr, 1'b0);
    if (ok && r == R_IO) chk("io_wdata_once", io_wdata, d);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    fault_clr = 1'b1;
    @(negedge clk); #1;
    fault_m = 1'b0;
    chk("fault_clr", bus_fault, 1'b0);
    @(posedge clk); #1;
    fault_clr = 1'b0;
  endtask

  function automatic logic [23:0] rand_addr(input int r);
    case (r)
      R_BIOS:  return 24'($urandom_range(0, 24'h000FFF));
      R_RAM:   return 24'(24'h001000 + $urandom_range(0, 31));
      R_IO:    return 24'($urandom_range(24'h002000, 24'h0020FF));
      R_CART:  return 24'($urandom_range(24'h002100, 24'h1FFFFF));
      default: return 24'($urandom_range(24'h200000, 24'hFFFFFF));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [23:0] a;
    bus.cpu_address = 24'h0; bus.cpu_data_out = 8'h0; bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0; bus.cpu_bus_status = 2'd0; bus.cpu_iack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdata", bus.cpu_data_in, 8'hFF);
    chk("rst_fault", bus_fault, 1'b0);
    chk("rst_io_wr", io_wr, 1'b0);
    chk("rst_cart_wr", cart_wr, 1'b0);
    chk("rst_irq_ack", irq_ack, 1'b0);
    chk("rst_io_wdata", io_wdata, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed scenarios.
    do_read(24'h000000, 8'h34, 8'h00, 8'h00);
    do_write(24'h001010, 8'hA5, 2'd2, 1, 1'b0);
    do_read(24'h001010, 8'h00, 8'h00, 8'h00);
    do_write(24'h001010, 8'h5A, 2'd2, 3, 1'b0);
    do_read(24'h001010, 8'h00, 8'h00, 8'h00);
    do_read(24'h002100, 8'h00, 8'h00, 8'h77);
    do_read(24'h300000, 8'h11, 8'h22, 8'h33);
    do_write(24'h002020, 8'h3C, 2'd2, 1, 1'b0);
    do_write(24'h000100, 8'h12, 2'd2, 1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("fault_sticky", bus_fault, 1'b1);
    do_clear();
    clr_on_write = 1'b1;
    do_write(24'h001005, 8'h44, 2'd3, 1, 1'b0);
    clr_on_write = 1'b0;
    do_clear();
    do_write(24'h001006, 8'h66, 2'd2, 1, 1'b1);
    do_clear();

    @(posedge clk); #1;
    bus.cpu_iack = 1'b1;
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); #1;
      if (k == 0) chk("irq_ack_first", irq_ack, 1'b1);
      cnt += int'(irq_ack);
    end
    chk("irq_ack_count", cnt, 1);
    do_read(24'h000000, 8'h00, 8'hEE, 8'hEE);
    do_read(24'h000001, 8'h21, 8'hEE, 8'hEE);
    @(posedge clk); #1;
    bus.cpu_iack = 1'b0;

    // Reset landing in the middle of an io_wr pulse.
    @(posedge clk); #1;
    bus.cpu_address = 24'h002055; bus.cpu_data_out = 8'h99;
    bus.cpu_write = 1'b1; bus.cpu_bus_status = 2'd2;
    @(negedge clk); #1;
    chk("pre_rst_io_wr", io_wr, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_io_wr", io_wr, 1'b0);
    chk("mid_rst_rdata", bus.cpu_data_in, 8'hFF);
    bus.cpu_write = 1'b0; bus.cpu_bus_status = 2'd0;
    last_m = 8'hFF; fault_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_io_wr", io_wr, 1'b0);
    do_read(24'h001010, 8'h00, 8'h00, 8'h00);

    // Randomized traffic; the 32-byte RAM window is seeded first so every read is known.
    for (int k = 0; k < 32; k++) do_write(24'h001000 + 24'(k), 8'($urandom), 2'd2, 1, 1'b0);
    for (int n = 0; n < 250; n++) begin
      int op;
      op = $urandom_range(0, 9);
      a  = rand_addr($urandom_range(0, 4));
      if (op <= 4)
        do_read(a, 8'($urandom), 8'($urandom), 8'($urandom));
      else if (op <= 8)
        do_write(a, 8'($urandom),
                 ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2,
                 $urandom_range(1, 3), $urandom_range(0, 15) == 0);
      else
        do_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
